// File: rtl/vga_pkg.sv
// Shared VGA constants: screen bounds, colour palette and rect_scanner state encoding.
// Purely declarative; no logic lives here.
package vga_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W_DEF = 3;

  localparam logic [COLOUR_W_DEF-1:0] BLACK = 3'd0;
  localparam logic [COLOUR_W_DEF-1:0] WHITE = 3'd7;
  localparam logic [COLOUR_W_DEF-1:0] WALL  = 3'd4;
  localparam logic [COLOUR_W_DEF-1:0] DUDE  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/rect_scanner_if.sv
// Command (start/busy/done) and pixel (plot/pix_ready) handshake bundle for rect_scanner.
// master = scanner side, slave = command issuer / pixel sink side.
interface rect_scanner_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);

  logic                start;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W-1:0]      w;
  logic [Y_W-1:0]      h;
  logic [COLOUR_W-1:0] colour;
  logic                outline;
  logic                pix_ready;
  logic                busy;
  logic                done;
  logic                plot;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  modport master (
    input  start, x0, y0, w, h, colour, outline, pix_ready,
    output busy, done, plot, x_out, y_out, colour_out
  );

  modport slave (
    output start, x0, y0, w, h, colour, outline, pix_ready,
    input  busy, done, plot, x_out, y_out, colour_out
  );

endinterface

// File: rtl/scan_counter2d.sv
// Nested raster counter: dx runs 0..w-1, then wraps and bumps dy; last marks (w-1, h-1).
// Next-offset values are exported so the caller can precompute the following pixel.
module scan_counter2d #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] dx_nxt,
  output logic [Y_W-1:0] dy_nxt,
  output logic           last
);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  logic           wrap;

  assign wrap   = (dx == w - X_W'(1));
  assign last   = wrap && (dy == h - Y_W'(1));
  assign dx_nxt = wrap ? '0 : dx + X_W'(1);
  assign dy_nxt = wrap ? dy + Y_W'(1) : dy;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      dx <= dx_nxt;
      dy <= dy_nxt;
    end
  end

endmodule

// File: rtl/rect_scanner.sv
// Walks a rectangle in raster order emitting registered plot requests; first plot 1 cycle after start.
// An emitted pixel holds until pix_ready; clipped or interior (outline mode) pixels pass in one cycle.
module rect_scanner
  import vga_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  rect_scanner_if.master bus
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  scan_state_t state, state_nxt;

  logic [X_W-1:0]      x0_r, w_r;
  logic [Y_W-1:0]      y0_r, h_r;
  logic [COLOUR_W-1:0] col_r;
  logic                outl_r;

  logic                plot_r, plot_nxt;
  logic [X_W-1:0]      x_r, x_nxt;
  logic [Y_W-1:0]      y_r, y_nxt;
  logic [COLOUR_W-1:0] c_r, c_nxt;
  logic                busy_r, busy_nxt;
  logic                done_r, done_nxt;

  logic                ld, cnt_clr, cnt_en;
  logic [X_W-1:0]      dx_nxt;
  logic [Y_W-1:0]      dy_nxt;
  logic                last;

  logic [X_W-1:0]      bx, bw, odx;
  logic [Y_W-1:0]      by, bh, ody;
  logic [COLOUR_W-1:0] bcol;
  logic                boutl;
  logic [X_W:0]        px;
  logic [Y_W:0]        py;
  logic                on_screen, border, emit;

  scan_counter2d #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .en     (cnt_en),
    .w      (w_r),
    .h      (h_r),
    .dx_nxt (dx_nxt),
    .dy_nxt (dy_nxt),
    .last   (last)
  );

  // Pixel to be presented next cycle: the command inputs at start, else the next raster offset.
  always_comb begin
    if (state == ST_IDLE) begin
      bx = bus.x0; by = bus.y0; bw = bus.w; bh = bus.h;
      bcol = bus.colour; boutl = bus.outline;
      odx = '0; ody = '0;
    end else begin
      bx = x0_r; by = y0_r; bw = w_r; bh = h_r;
      bcol = col_r; boutl = outl_r;
      odx = dx_nxt; ody = dy_nxt;
    end
    px        = {1'b0, bx} + {1'b0, odx};
    py        = {1'b0, by} + {1'b0, ody};
    on_screen = (px < SCR_W) && (py < SCR_H);
    border    = (odx == '0) || (odx == bw - X_W'(1)) ||
                (ody == '0) || (ody == bh - Y_W'(1));
    emit      = on_screen && (!boutl || border);
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    plot_nxt  = plot_r;
    x_nxt     = x_r;
    y_nxt     = y_r;
    c_nxt     = c_r;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          ld       = 1'b1;
          cnt_clr  = 1'b1;
          busy_nxt = 1'b1;
          if (bus.w == '0 || bus.h == '0) begin
            state_nxt = ST_FIN;
            plot_nxt  = 1'b0;
          end else begin
            state_nxt = ST_SCAN;
            plot_nxt  = emit;
            if (emit) begin
              x_nxt = px[X_W-1:0];
              y_nxt = py[Y_W-1:0];
              c_nxt = bcol;
            end
          end
        end
      end
      ST_SCAN: begin
        if (!plot_r || bus.pix_ready) begin
          cnt_en = 1'b1;
          if (last) begin
            state_nxt = ST_FIN;
            plot_nxt  = 1'b0;
          end else begin
            plot_nxt = emit;
            if (emit) begin
              x_nxt = px[X_W-1:0];
              y_nxt = py[Y_W-1:0];
              c_nxt = bcol;
            end
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        plot_nxt  = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_r   <= '0;
      y0_r   <= '0;
      w_r    <= '0;
      h_r    <= '0;
      col_r  <= '0;
      outl_r <= 1'b0;
    end else if (ld) begin
      x0_r   <= bus.x0;
      y0_r   <= bus.y0;
      w_r    <= bus.w;
      h_r    <= bus.h;
      col_r  <= bus.colour;
      outl_r <= bus.outline;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      plot_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      c_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      plot_r <= plot_nxt;
      x_r    <= x_nxt;
      y_r    <= y_nxt;
      c_r    <= c_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
    end
  end

  assign bus.plot       = plot_r;
  assign bus.x_out      = x_r;
  assign bus.y_out      = y_r;
  assign bus.colour_out = c_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_rect_scanner.sv
// Directed bench for rect_scanner: stimulus pushes expected pixels, a negedge monitor pops them on accept.
module tb_rect_scanner;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  pix_t q[$];
  pix_t cur;
  pix_t hold_p;
  logic hold_v = 1'b0;

  always #5 clk = ~clk;

  rect_scanner_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

  rect_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign cur = {bus.x_out, bus.y_out, bus.colour_out};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp_pix(input int x, input int y, input int c);
    q.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  // Monitor: checks hold stability during stalls and scoreboards every accepted plot.
  always @(negedge clk) begin
    pix_t e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!bus.plot || cur != hold_p) begin
          errors++;
          $display("FAIL hold: got plot=%0d (%0d,%0d,%0d) expected plot=1 (%0d,%0d,%0d)",
                   bus.plot, cur.x, cur.y, cur.c, hold_p.x, hold_p.y, hold_p.c);
        end
      end
      if (bus.plot && bus.pix_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL plot_unexpected: got (%0d,%0d,%0d) expected no plot", cur.x, cur.y, cur.c);
        end else begin
          e = q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL plot_value: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     cur.x, cur.y, cur.c, e.x, e.y, e.c);
          end
        end
      end
      hold_v = bus.plot && !bus.pix_ready;
      hold_p = cur;
    end
  end

  // Issues one command; lat = cycle (1 = first cycle after the start edge) on which done is seen.
  task automatic send(input int x0, input int y0, input int w, input int h, input int c,
                      input int o, input logic [31:0] stall, input int restart_k,
                      output int lat, output int bcyc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x0 = 8'(x0); bus.y0 = 7'(y0); bus.w = 8'(w); bus.h = 7'(h);
    bus.colour = 3'(c); bus.outline = o[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x0 = 8'd1; bus.y0 = 7'd1; bus.w = 8'd2; bus.h = 7'd2;
    bus.colour = 3'd1; bus.outline = 1'b1;
    bus.pix_ready = !stall[1];
    lat = -1;
    bcyc = 0;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        bus.pix_ready = (k < 32) ? !stall[k[4:0]] : 1'b1;
        bus.start = (k == restart_k);
      end
      @(negedge clk);
      if (bus.busy) bcyc++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.pix_ready = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    int lat, b, nd;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
    bus.colour = '0; bus.outline = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_x", int'(bus.x_out), 0);
    chk("rst_y", int'(bus.y_out), 0);
    chk("rst_colour", int'(bus.colour_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Filled 3x2, ready high
    exp_pix(10, 5, 4); exp_pix(11, 5, 4); exp_pix(12, 5, 4);
    exp_pix(10, 6, 4); exp_pix(11, 6, 4); exp_pix(12, 6, 4);
    send(10, 5, 3, 2, 4, 0, 32'h0, 0, lat, b);
    chk("fill_done_cycle", lat, 8);
    chk("fill_busy_cycles", b, 7);
    chk("fill_queue_empty", q.size(), 0);

    // Outline 4x3: interior (1,1),(2,1) skipped
    exp_pix(0, 0, 7); exp_pix(1, 0, 7); exp_pix(2, 0, 7); exp_pix(3, 0, 7);
    exp_pix(0, 1, 7); exp_pix(3, 1, 7);
    exp_pix(0, 2, 7); exp_pix(1, 2, 7); exp_pix(2, 2, 7); exp_pix(3, 2, 7);
    send(0, 0, 4, 3, 7, 1, 32'h0, 0, lat, b);
    chk("outline_done_cycle", lat, 14);
    chk("outline_busy_cycles", b, 13);
    chk("outline_queue_empty", q.size(), 0);

    // Backpressure: ready low on cycles 2..4 while (11,5) is presented
    exp_pix(10, 5, 4); exp_pix(11, 5, 4); exp_pix(12, 5, 4);
    exp_pix(10, 6, 4); exp_pix(11, 6, 4); exp_pix(12, 6, 4);
    send(10, 5, 3, 2, 4, 0, 32'h0000_001C, 0, lat, b);
    chk("stall_done_cycle", lat, 11);
    chk("stall_busy_cycles", b, 10);
    chk("stall_queue_empty", q.size(), 0);

    // Clipping at bottom-right corner
    exp_pix(158, 119, 2); exp_pix(159, 119, 2);
    send(158, 119, 4, 2, 2, 0, 32'h0, 0, lat, b);
    chk("clip_done_cycle", lat, 10);
    chk("clip_queue_empty", q.size(), 0);

    // x0+dx crosses 255: must stay off-screen, never wrap to small x
    send(250, 0, 10, 1, 7, 0, 32'h0, 0, lat, b);
    chk("wrap_done_cycle", lat, 12);
    chk("wrap_busy_cycles", b, 11);

    // Zero-size commands
    send(5, 5, 0, 3, 1, 0, 32'h0, 0, lat, b);
    chk("w0_done_cycle", lat, 2);
    chk("w0_busy_cycles", b, 1);
    send(5, 5, 3, 0, 1, 0, 32'h0, 0, lat, b);
    chk("h0_done_cycle", lat, 2);

    // Start pulsed mid-command is ignored
    exp_pix(20, 30, 2); exp_pix(21, 30, 2); exp_pix(20, 31, 2); exp_pix(21, 31, 2);
    send(20, 30, 2, 2, 2, 0, 32'h0, 2, lat, b);
    chk("restart_done_cycle", lat, 6);
    chk("restart_queue_empty", q.size(), 0);

    // Degenerate outline, single column
    exp_pix(40, 10, 5); exp_pix(40, 11, 5); exp_pix(40, 12, 5);
    send(40, 10, 1, 3, 5, 1, 32'h0, 0, lat, b);
    chk("col_outline_done_cycle", lat, 5);
    chk("col_outline_queue_empty", q.size(), 0);

    // Reset during the 3rd plot of a 5x5 fill
    exp_pix(0, 0, 3); exp_pix(1, 0, 3);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd5; bus.h = 7'd5;
    bus.colour = 3'd3; bus.outline = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_plot", int'(bus.plot), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_x", int'(bus.x_out), 0);
    chk("midrst_y", int'(bus.y_out), 0);
    chk("midrst_colour", int'(bus.colour_out), 0);
    chk("midrst_queue_empty", q.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done || bus.plot) nd++;
    end
    chk("midrst_no_activity", nd, 0);

    exp_pix(10, 5, 4); exp_pix(11, 5, 4); exp_pix(12, 5, 4);
    exp_pix(10, 6, 4); exp_pix(11, 6, 4); exp_pix(12, 6, 4);
    send(10, 5, 3, 2, 4, 0, 32'h0, 0, lat, b);
    chk("postrst_done_cycle", lat, 8);
    chk("postrst_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_scanner.md
Name: rect_scanner

Overview:
Parametrised pixel-scan engine that walks a rectangular region of the frame buffer and emits one (x, y, colour) plot request per pixel for the VGA adapter. It is the successor to the fixed-bounds screen-update counter: rectangle origin, size, colour and mode are per-command inputs. It adds fill/outline modes, screen clipping, a start/busy/done handshake, and backpressure from the pixel sink. The game datapath issues one command per wall, player or erase operation.

Parameters:
X_W, 8, width of x coordinate and width operand
Y_W, 7, width of y coordinate and height operand
COLOUR_W, 3, colour width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
x0  in  X_W  rectangle left column
y0  in  Y_W  rectangle top row
w  in  X_W  rectangle width in pixels; 0 means empty
h  in  Y_W  rectangle height in pixels; 0 means empty
colour  in  COLOUR_W  plot colour
outline  in  1  0 = filled rectangle, 1 = border pixels only
pix_ready  in  1  sink accepts the current plot this cycle
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
plot  out  1  x_out/y_out/colour_out valid
x_out  out  X_W  pixel column
y_out  out  Y_W  pixel row
colour_out  out  COLOUR_W  pixel colour

Behaviour:
- Reset: state IDLE. busy, done, plot, x_out, y_out and colour_out are all 0. Reset mid-command aborts it immediately; no done pulse is produced.
- States: IDLE, SCAN, FIN.
- IDLE, start=1:
  - latch x0, y0, w, h, colour and outline; clear offsets dx=dy=0.
  - if w==0 or h==0, go to FIN with no plots; otherwise go to SCAN.
  - busy rises the cycle after start.
  - start outside IDLE is ignored, as are input changes after latch.
- SCAN:
  - Current pixel is (x0+dx, y0+dy), computed at X_W+1 / Y_W+1 bits so that wrap-around is treated as off-screen, never as a wrapped coordinate.
  - A pixel is emitted if on-screen (x < SCREEN_W and y < SCREEN_H) and, in outline mode, also on the border (dx==0, dx==w-1, dy==0 or dy==h-1).
  - Emitted pixel: plot=1 with registered outputs. Hold plot and all outputs stable until pix_ready=1, then advance.
  - Non-emitted pixel: advances in one cycle with plot=0; pix_ready is ignored.
  - Order is raster: dx increments first; at dx==w-1, dx resets to 0 and dy increments.
  - After the last pixel (dx==w-1, dy==h-1) advances, go to FIN.
- Latency: the first plot is asserted 1 cycle after the start cycle. With pix_ready tied high, a filled unclipped rectangle takes exactly w*h SCAN cycles.
- FIN: done=1 for exactly one cycle, busy=0, plot=0, then return to IDLE. A new start is accepted in the cycle after FIN, i.e. back-to-back commands have a 1-cycle gap.
- Degenerate shapes:
  - w==1 or h==1 in outline mode emits the same pixels as fill mode.
  - A fully off-screen rectangle produces no plots but still scans every pixel and then pulses done.
- Outputs hold their last value while plot=0 (don't-care to the sink), except during reset.

Decomposition:
- Shared package vga_pkg:
  - SCREEN_W / SCREEN_H defaults
  - colour width and named colour constants (BLACK, WHITE, WALL, DUDE)
  - state encoding localparams for rect_scanner
- One natural sub-module: scan_counter2d, the nested dx/dy counter with enable, a wrap flag and a last flag. It generalises the existing sync_counter.

Test Plan:
- Fill with ready tied high: x0=10, y0=5, w=3, h=2, colour=4, outline=0 -> 6 plots in order (10,5) (11,5) (12,5) (10,6) (11,6) (12,6), all colour 4; done pulses on cycle 8 after start; busy high on cycles 1-7.
- Outline: x0=0, y0=0, w=4, h=3, outline=1 -> 10 plots; (1,1) and (2,1) are never emitted; 12 SCAN cycles, then done.
- Backpressure: same as test 1 with pix_ready low for 3 cycles on the second pixel -> (11,5) is held stable for 4 cycles; no pixel is dropped or duplicated; done is delayed by 3 cycles.
- Clipping and wrap: x0=158, y0=119, w=4, h=2 -> only (158,119) and (159,119) are emitted; done follows 8 SCAN cycles. Separately, x0=250, w=10 -> no plot has x < 10 (no wrap).
- Zero size and ignored start: w=0 -> done one cycle after the FIN entry with no plot. A start pulsed during a busy command changes neither the latched values nor the plot count.
- Reset mid-scan: assert reset on the 3rd plot of a 5x5 fill -> the next cycle has all outputs 0 and state IDLE with no done pulse; a new command afterwards runs normally.
